// File: rtl/hazard_ctrl_s.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_s
// Description : Execute-stage hazard controller for a 5-stage RV32I pipeline.
//               Shadows rd/write/load info for the ID/EX, EX/MEM and MEM/WB
//               slots, produces registered forwarding selects, and raises
//               stall/bubble for load-use hazards, for any RAW hazard when
//               forwarding is off, and bubbles on a taken branch.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_s #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  isForw_ON,
    input  logic                  id_valid,
    input  logic [6:0]            id_op,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  branch_taken,
    output logic [1:0]            forwA,
    output logic [1:0]            forwB,
    output logic                  stall,
    output logic                  bubble,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_LD   = 7'b0000011;
    localparam logic [6:0] c_OP_ST   = 7'b0100011;
    localparam logic [6:0] c_OP_BR   = 7'b1100011;
    localparam logic [6:0] c_OP_JALR = 7'b1100111;
    localparam logic [6:0] c_OP_LUI  = 7'b0110111;
    localparam logic [6:0] c_OP_AUIP = 7'b0010111;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;

    localparam logic [1:0]            c_SEL_REG = 2'b00;
    localparam logic [1:0]            c_SEL_EXM = 2'b01;
    localparam logic [1:0]            c_SEL_MWB = 2'b10;
    localparam logic [REG_ADDR_W-1:0] c_X0      = '0;
    localparam logic [CNT_W-1:0]      c_CNT_MAX = '1;

    // Shadow slots: destination index, writes-rd flag, is-load flag
    logic [REG_ADDR_W-1:0] r_ex_rd, r_mem_rd, r_wb_rd;
    logic                  r_ex_wr, r_mem_wr, r_wb_wr;
    logic                  r_ex_ld, r_mem_ld, r_wb_ld;

    logic [1:0]       r_forw_a, r_forw_b;
    logic [CNT_W-1:0] r_stall_count;

    logic       w_uses_rs1, w_uses_rs2, w_writes_rd, w_is_load;
    logic       w_a_ex, w_a_mem, w_a_wb, w_b_ex, w_b_mem, w_b_wb;
    logic       w_hz_ex, w_hz_any, w_hazard;
    logic       w_stall, w_bubble;
    logic [1:0] w_sel_a, w_sel_b;

    // A source matches a slot only if the slot writes a non-x0 register
    function automatic logic slot_match(input logic wr,
                                        input logic [REG_ADDR_W-1:0] rd,
                                        input logic [REG_ADDR_W-1:0] src);
        return wr && (rd != c_X0) && (rd == src);
    endfunction

    // Opcode decode of the ID instruction; invalid slot reads/writes nothing
    always_comb begin
        w_uses_rs1  = 1'b0;
        w_uses_rs2  = 1'b0;
        w_writes_rd = 1'b0;
        w_is_load   = 1'b0;
        if (id_valid) begin
            case (id_op)
                c_OP_R:    begin w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; w_writes_rd = 1'b1; end
                c_OP_I:    begin w_uses_rs1 = 1'b1; w_writes_rd = 1'b1; end
                c_OP_LD:   begin w_uses_rs1 = 1'b1; w_writes_rd = 1'b1; w_is_load = 1'b1; end
                c_OP_ST:   begin w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; end
                c_OP_BR:   begin w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; end
                c_OP_JALR: begin w_uses_rs1 = 1'b1; w_writes_rd = 1'b1; end
                c_OP_LUI,
                c_OP_AUIP,
                c_OP_JAL:  w_writes_rd = 1'b1;
                default:   ;
            endcase
        end
    end

    // Hazard detection, stall/bubble generation and next forward selects
    always_comb begin
        w_a_ex  = w_uses_rs1 && slot_match(r_ex_wr,  r_ex_rd,  id_rs1);
        w_a_mem = w_uses_rs1 && slot_match(r_mem_wr, r_mem_rd, id_rs1);
        w_a_wb  = w_uses_rs1 && slot_match(r_wb_wr,  r_wb_rd,  id_rs1);
        w_b_ex  = w_uses_rs2 && slot_match(r_ex_wr,  r_ex_rd,  id_rs2);
        w_b_mem = w_uses_rs2 && slot_match(r_mem_wr, r_mem_rd, id_rs2);
        w_b_wb  = w_uses_rs2 && slot_match(r_wb_wr,  r_wb_rd,  id_rs2);

        w_hz_ex  = w_a_ex || w_b_ex;
        w_hz_any = w_hz_ex || w_a_mem || w_b_mem || w_a_wb || w_b_wb;
        // With forwarding only a load in EX cannot be bypassed in time
        w_hazard = isForw_ON ? (w_hz_ex && r_ex_ld) : w_hz_any;

        w_stall  = w_hazard && !branch_taken;
        w_bubble = w_hazard || branch_taken;

        // Nearer producer (current EX, which moves to MEM) takes priority
        w_sel_a = w_a_ex ? c_SEL_EXM : (w_a_mem ? c_SEL_MWB : c_SEL_REG);
        w_sel_b = w_b_ex ? c_SEL_EXM : (w_b_mem ? c_SEL_MWB : c_SEL_REG);
    end

    // Slot shift, forward select registers and saturating stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_rd       <= '0;
            r_ex_wr       <= 1'b0;
            r_ex_ld       <= 1'b0;
            r_mem_rd      <= '0;
            r_mem_wr      <= 1'b0;
            r_mem_ld      <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_wr       <= 1'b0;
            r_wb_ld       <= 1'b0;
            r_forw_a      <= c_SEL_REG;
            r_forw_b      <= c_SEL_REG;
            r_stall_count <= '0;
        end else begin
            r_wb_rd  <= r_mem_rd;
            r_wb_wr  <= r_mem_wr;
            r_wb_ld  <= r_mem_ld;
            r_mem_rd <= r_ex_rd;
            r_mem_wr <= r_ex_wr;
            r_mem_ld <= r_ex_ld;
            if (w_bubble) begin
                r_ex_rd <= '0;
                r_ex_wr <= 1'b0;
                r_ex_ld <= 1'b0;
            end else begin
                r_ex_rd <= id_rd;
                r_ex_wr <= w_writes_rd;
                r_ex_ld <= w_is_load;
            end
            if (!w_bubble && isForw_ON) begin
                r_forw_a <= w_sel_a;
                r_forw_b <= w_sel_b;
            end else begin
                r_forw_a <= c_SEL_REG;
                r_forw_b <= c_SEL_REG;
            end
            if (w_stall && (r_stall_count != c_CNT_MAX))
                r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign forwA       = r_forw_a;
    assign forwB       = r_forw_b;
    assign stall       = w_stall;
    assign bubble      = w_bubble;
    assign stall_count = r_stall_count;

    // r_wb_ld is carried for slot completeness; nothing consumes it yet
    logic w_unused;
    assign w_unused = r_wb_ld;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_s.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl_s
// Description : Directed self-checking bench for hazard_ctrl_s.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_s;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;

    logic        clk = 1'b0;
    logic        rst;
    logic        isForw_ON;
    logic        id_valid;
    logic [6:0]  id_op;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        branch_taken;
    logic [1:0]  forwA, forwB;
    logic        stall, bubble;
    logic [31:0] stall_count;

    int n_checks = 0;
    int n_errors = 0;

    hazard_ctrl_s #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .isForw_ON    (isForw_ON),
        .id_valid     (id_valid),
        .id_op        (id_op),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .branch_taken (branch_taken),
        .forwA        (forwA),
        .forwB        (forwB),
        .stall        (stall),
        .bubble       (bubble),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; inputs change and outputs are sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [6:0] op,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        id_valid = v;
        id_op    = op;
        id_rs1   = rs1;
        id_rs2   = rs2;
        id_rd    = rd;
        #1;
    endtask

    // Empty the shadow slots with invalid ID instructions
    task automatic drain();
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1; isForw_ON = 1'b1; branch_taken = 1'b0;
        id_valid = 1'b0; id_op = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("reset_forwA", {30'd0, forwA}, 32'd0);
        chk("reset_forwB", {30'd0, forwB}, 32'd0);
        chk("reset_count", stall_count, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_bubble", {31'd0, bubble}, 32'd0);

        // EX/MEM forward: add x5,x1,x2 ; add x6,x5,x3
        set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd5); tick();
        set_id(1'b1, OP_R, 5'd5, 5'd3, 5'd6);
        chk("exm_stall", {31'd0, stall}, 32'd0);
        chk("exm_bubble", {31'd0, bubble}, 32'd0);
        tick();
        chk("exm_forwA", {30'd0, forwA}, 32'd1);
        chk("exm_forwB", {30'd0, forwB}, 32'd0);

        // MEM/WB forward: add x5 ; nop ; sub x7,x4,x5
        drain();
        set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd5); tick();
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0); tick();
        set_id(1'b1, OP_R, 5'd4, 5'd5, 5'd7);
        chk("mwb_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("mwb_forwA", {30'd0, forwA}, 32'd0);
        chk("mwb_forwB", {30'd0, forwB}, 32'd2);

        // Priority: add x5 ; add x5 ; add x8,x5,x5 -> nearer producer
        drain();
        set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd5); tick();
        set_id(1'b1, OP_R, 5'd3, 5'd4, 5'd5); tick();
        set_id(1'b1, OP_R, 5'd5, 5'd5, 5'd8); tick();
        chk("prio_forwA", {30'd0, forwA}, 32'd1);
        chk("prio_forwB", {30'd0, forwB}, 32'd1);

        // Load-use: lw x5,0(x1) ; add x6,x5,x5
        drain();
        set_id(1'b1, OP_LD, 5'd1, 5'd0, 5'd5); tick();
        set_id(1'b1, OP_R, 5'd5, 5'd5, 5'd6);
        chk("lu_stall", {31'd0, stall}, 32'd1);
        chk("lu_bubble", {31'd0, bubble}, 32'd1);
        tick();
        chk("lu_count", stall_count, 32'd1);
        chk("lu_bubble_forwA", {30'd0, forwA}, 32'd0);
        chk("lu_stall_released", {31'd0, stall}, 32'd0);
        chk("lu_bubble_released", {31'd0, bubble}, 32'd0);
        tick();
        chk("lu_forwA", {30'd0, forwA}, 32'd2);
        chk("lu_forwB", {30'd0, forwB}, 32'd2);

        // x0 never matches: addi x0,x0,1 ; add x6,x0,x0
        drain();
        set_id(1'b1, OP_I, 5'd0, 5'd0, 5'd0); tick();
        set_id(1'b1, OP_R, 5'd0, 5'd0, 5'd6);
        chk("x0_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("x0_forwA", {30'd0, forwA}, 32'd0);

        // Load-use coinciding with a taken branch: flush wins
        drain();
        set_id(1'b1, OP_LD, 5'd1, 5'd0, 5'd5); tick();
        set_id(1'b1, OP_R, 5'd5, 5'd5, 5'd6);
        branch_taken = 1'b1; #1;
        chk("flush_stall", {31'd0, stall}, 32'd0);
        chk("flush_bubble", {31'd0, bubble}, 32'd1);
        tick();
        branch_taken = 1'b0;
        chk("flush_count", stall_count, 32'd1);
        chk("flush_forwA", {30'd0, forwA}, 32'd0);
        // EX slot now empty, load in MEM: a reader of x5 needs no stall
        set_id(1'b1, OP_R, 5'd5, 5'd0, 5'd7);
        chk("flush_ex_empty", {31'd0, stall}, 32'd0);
        tick();
        chk("flush_next_forwA", {30'd0, forwA}, 32'd2);

        // Forwarding off: add x5 ; add x6,x5,x0 -> three stall cycles
        drain();
        isForw_ON = 1'b0;
        set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd5); tick();
        set_id(1'b1, OP_R, 5'd5, 5'd0, 5'd6);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("off_stall%0d", i), {31'd0, stall}, 32'd1);
            chk($sformatf("off_bubble%0d", i), {31'd0, bubble}, 32'd1);
            tick();
        end
        chk("off_release", {31'd0, stall}, 32'd0);
        chk("off_count", stall_count, 32'd4);
        tick();
        chk("off_forwA", {30'd0, forwA}, 32'd0);

        // Reset during the second forwarding-off stall cycle
        drain();
        set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd5); tick();
        set_id(1'b1, OP_R, 5'd5, 5'd0, 5'd6);
        chk("rs_stall1", {31'd0, stall}, 32'd1);
        tick();
        chk("rs_stall2", {31'd0, stall}, 32'd1);
        chk("rs_count_pre", stall_count, 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        chk("rs_stall_after", {31'd0, stall}, 32'd0);
        chk("rs_count", stall_count, 32'd0);
        chk("rs_forwA", {30'd0, forwA}, 32'd0);
        chk("rs_forwB", {30'd0, forwB}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl_s.md
Name: hazard_ctrl_s

Overview:
Pipeline hazard controller that sequences the execute stage of the 5-stage RV32I core. It tracks destination and source information for the ID/EX, EX/MEM and MEM/WB slots in internal shadow registers. It drives the registered forwA/forwB selects consumed by the EX-stage forwarding mux, and raises stall/bubble for load-use hazards. When forwarding is disabled it raises stall/bubble for every RAW hazard, and it squashes the ID instruction on a taken branch.

Parameters:
REG_ADDR_W, 5, register index width
CNT_W, 32, width of saturating stall counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
isForw_ON  in  1  1 = forwarding enabled, 0 = resolve all RAW hazards by stalling
id_valid  in  1  ID slot holds a real instruction
id_op  in  7  opcode of ID instruction
id_rs1  in  REG_ADDR_W  source 1 of ID instruction
id_rs2  in  REG_ADDR_W  source 2 of ID instruction
id_rd  in  REG_ADDR_W  destination of ID instruction
branch_taken  in  1  taken branch/jump resolved in EX this cycle
forwA  out  2  operand1 select for instruction in EX: 00 reg, 01 exmem_result, 10 memwb_result
forwB  out  2  operand2/store-data select, same encoding
stall  out  1  hold PC and IF/ID this cycle (combinational)
bubble  out  1  ID/EX loads a NOP next edge (combinational)
stall_count  out  CNT_W  number of stall cycles since reset, saturating

Behaviour:
- Reset (synchronous, active-high):
  - All shadow slots invalid: wr=0, ld=0, rd=0.
  - forwA=forwB=00, stall_count=0.
  - rst overrides branch_taken and stall in the same cycle.
- Opcode decode, applied to the ID instruction:
  - uses_rs1 for 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - uses_rs2 for 0110011, 0100011, 1100011.
  - writes_rd for 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111.
  - is_load for 0000011.
  - Unknown opcode: no reads, no writes.
  - id_valid=0: treated as no reads, no writes.
- A source matches a slot when: slot.wr=1, slot.rd != 0, and slot.rd equals the source index. x0 never matches.
- Hazard detection, evaluated combinationally each cycle on the ID instruction:
  - isForw_ON=1: hazard when a used source matches EX and EX.ld=1 (load-use). Exactly one stall cycle.
  - isForw_ON=0: hazard when a used source matches EX, MEM or WB. Up to 3 stall cycles; no write-through register file is assumed.
  - stall = hazard AND NOT branch_taken.
  - bubble = hazard OR branch_taken.
- Slot advance at every clock edge (not rst):
  - WB <= MEM, MEM <= EX, unconditionally.
  - EX <= ID fields (rd, wr, ld) when bubble=0.
  - EX <= invalid (wr=0, ld=0) when bubble=1.
- Forward selects (registered, aligned with the instruction entering EX):
  - Computed for each used source of the ID instruction against the current EX slot (becomes MEM) and the current MEM slot (becomes WB).
  - EX slot match gives 01; otherwise MEM slot match gives 10; otherwise 00. The nearer producer wins when both match.
  - Loaded into forwA/forwB only when bubble=0 and isForw_ON=1. When bubble=1 or isForw_ON=0, load 00.
- Load-use: after the single bubble the load sits in MEM/WB, so the re-evaluated ID instruction gets select 10.
- branch_taken and hazard in the same cycle: flush wins. stall=0, bubble=1; the held ID instruction is discarded.
- isForw_ON changes apply from the next evaluation; in-flight forward selects are not altered.
- stall_count increments by 1 on every cycle with stall=1 and holds at all-ones.

Test Plan:
- Forward from EX/MEM: add x5,x1,x2 followed by add x6,x5,x3, isForw_ON=1 -> no stall; second instruction enters EX with forwA=01, forwB=00.
- Forward from MEM/WB: add x5 ; nop ; sub x7,x4,x5 -> forwA=00, forwB=10. Both-match priority: add x5 ; add x5 ; add x8,x5,x5 -> forwA=forwB=01.
- Load-use stall: lw x5,0(x1) followed by add x6,x5,x5 -> stall=1 and bubble=1 for exactly 1 cycle, stall_count=1; add then enters EX with forwA=forwB=10.
- Forwarding off: add x5 followed by add x6,x5,x0 with isForw_ON=0 -> stall for 3 consecutive cycles, then the add enters EX with forwA=00; stall_count=3.
- x0 and flush:
  - addi x0,x0,1 followed by add x6,x0,x0 -> no stall, forwA=00.
  - Load-use hazard coinciding with branch_taken=1 -> stall=0, bubble=1, EX slot invalid next cycle, stall_count unchanged.
- Reset mid-stall: assert rst during the second of 3 forwarding-off stall cycles -> next cycle stall=0, forwA=forwB=00, stall_count=0, all slots invalid.
